// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller.
// Holds the access size codes, the FSM state encoding and the lane helpers.
// Both the controller and the lane merge block use these helpers.
package mem_lsu_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_DATA,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_ERR
    } lsu_state_e;

    // A request is rejected when its size code is illegal.
    // It is also rejected when its offset does not match the natural alignment of its size.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pull the addressed lane out of a RAM word, then sign- or zero-extend it.
    // A word access returns the RAM word unchanged.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            SIZE_H:  res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the old word with the low bits of the new data.
    // The new data is right-justified.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] new_data,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] shifted;
        logic [31:0] res;
        case (size)
            SIZE_B: begin
                mask    = 32'h0000_00FF << {off, 3'b000};
                shifted = {24'h0, new_data[7:0]} << {off, 3'b000};
                res     = (old_word & ~mask) | (shifted & mask);
            end
            SIZE_H: begin
                mask    = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                shifted = off[1] ? {new_data[15:0], 16'h0} : {16'h0, new_data[15:0]};
                res     = (old_word & ~mask) | (shifted & mask);
            end
            default: res = new_data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lsu_ctrl_if.sv
// Bus between the memory stage, the load/store controller and the data block RAM.
// The master modport is the CPU side, the slave modport is the controller
// and the ram modport is the block RAM instance.
interface mem_lsu_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int RAM_AW = ADDR_W - 2
);
    logic              Req_Valid;
    logic              Req_Ready;
    logic              Req_Write;
    logic [1:0]        Req_Size;
    logic              Req_Signed;
    logic [ADDR_W-1:0] Req_Addr;
    logic [31:0]       Req_WData;
    logic              Rsp_Valid;
    logic              Rsp_Err;
    logic [31:0]       Rsp_RData;
    logic              Ram_We;
    logic [RAM_AW-1:0] Ram_Addr;
    logic [31:0]       Ram_Din;
    logic [31:0]       Ram_Dout;

    modport master (
        output Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Addr, Req_WData,
        input  Req_Ready, Rsp_Valid, Rsp_Err, Rsp_RData
    );

    modport slave (
        input  Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Addr, Req_WData,
        output Req_Ready, Rsp_Valid, Rsp_Err, Rsp_RData,
        output Ram_We, Ram_Addr, Ram_Din,
        input  Ram_Dout
    );

    modport ram (
        input  Ram_We, Ram_Addr, Ram_Din,
        output Ram_Dout
    );

endinterface

// File: rtl/mem_lsu_ctrl_lane_merge.sv
// Combinational lane logic.
// It merges store data into the old RAM word for sub-word stores.
// It also extracts and extends the addressed lane of a RAM word for loads.
module mem_lane_merge
    import mem_lsu_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        load_signed,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    // Both paths are evaluated from the same latched size and offset.
    always_comb begin
        merged_word = lane_merge(old_word, new_data, size, offset);
        load_data   = lane_extract(old_word, size, offset, load_signed);
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Data-memory load/store controller.
// It accepts one request at a time over a valid/ready handshake.
// It drives a single-port RAM with a 1-cycle registered read.
// Sub-word stores run as a read-modify-write through the lane merge block.
module mem_lsu_ctrl
    import mem_lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RAM_AW = ADDR_W - 2
) (
    input  logic           Clk_m,
    input  logic           Rst_m,
    mem_lsu_ctrl_if.slave  bus
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [31:0]       merged_word;
    logic [31:0]       load_data;

    mem_lane_merge u_lane (
        .old_word    (bus.Ram_Dout),
        .new_data    (wdata_q),
        .size        (size_q),
        .offset      (off_q),
        .load_signed (signed_q),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Next-state and next-output logic.
    // Request fields are captured only on the accept cycle.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        off_d       = off_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Req_Valid) begin
                    size_d   = bus.Req_Size;
                    off_d    = bus.Req_Addr[1:0];
                    signed_d = bus.Req_Signed;
                    wdata_d  = bus.Req_WData;
                    if (req_is_bad(bus.Req_Size, bus.Req_Addr[1:0])) begin
                        state_d = ST_ERR;
                    end else begin
                        ram_addr_d = bus.Req_Addr[ADDR_W-1:2];
                        if (bus.Req_Write) begin
                            ram_din_d = bus.Req_WData;
                            state_d   = (bus.Req_Size == SIZE_W) ? ST_WR : ST_RMW_RD;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
                state_d     = ST_IDLE;
            end
            ST_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = 32'h0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    // Reset returns the controller to idle with every output cleared.
    always_ff @(posedge Clk_m or posedge Rst_m) begin
        if (Rst_m) begin
            state_q     <= ST_IDLE;
            size_q      <= SIZE_B;
            off_q       <= 2'b00;
            signed_q    <= 1'b0;
            wdata_q     <= 32'h0;
            ram_addr_q  <= '0;
            ram_din_q   <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            off_q       <= off_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Ready and write enable decode straight from the state register.
    // Because of this, a reset drops the write enable at once.
    // During the merge write cycle the RAM data comes from the lane merge block.
    always_comb begin
        bus.Req_Ready = (state_q == ST_IDLE);
        bus.Ram_We    = (state_q == ST_WR) || (state_q == ST_RMW_WR);
        bus.Ram_Din   = (state_q == ST_RMW_WR) ? merged_word : ram_din_q;
        bus.Ram_Addr  = ram_addr_q;
        bus.Rsp_Valid = rsp_valid_q;
        bus.Rsp_Err   = rsp_err_q;
        bus.Rsp_RData = rsp_rdata_q;
    end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed testbench for mem_lsu_ctrl.
// It contains a behavioural 64x32 RAM with a registered read port.
module tb_mem_lsu_ctrl;

    logic Clk_m = 1'b0;
    logic Rst_m = 1'b1;

    mem_lsu_ctrl_if bus_if ();

    mem_lsu_ctrl dut (
        .Clk_m (Clk_m),
        .Rst_m (Rst_m),
        .bus   (bus_if)
    );

    always #5 Clk_m = ~Clk_m;

    int num_checks = 0;
    int num_errors = 0;

    logic [31:0] ram_mem [64];
    int          we_count = 0;
    logic        mon_on = 1'b0;
    int          busy_cnt = 0;
    int          rsp_count = 0;
    logic [31:0] rsp_data [8];
    logic        rsp_err [8];

    // Behavioural block RAM: synchronous write, registered read-first output.
    always @(posedge Clk_m) begin
        if (bus_if.Ram_We) ram_mem[bus_if.Ram_Addr] <= bus_if.Ram_Din;
        bus_if.Ram_Dout <= ram_mem[bus_if.Ram_Addr];
    end

    // Count cycles with the write enable high, plus busy cycles while monitoring.
    always @(negedge Clk_m) begin
        if (bus_if.Ram_We) we_count++;
        if (mon_on && !bus_if.Req_Ready) busy_cnt++;
    end

    // Record response pulses in arrival order while monitoring.
    always @(posedge Clk_m) begin
        #1;
        if (mon_on && bus_if.Rsp_Valid && rsp_count < 8) begin
            rsp_data[rsp_count] = bus_if.Rsp_RData;
            rsp_err[rsp_count]  = bus_if.Rsp_Err;
            rsp_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for its response pulse.
    // Returns the data, the error flag and the number of edges after accept.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [7:0] ad, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er, output int lat);
        int  n;
        logic got;
        @(negedge Clk_m);
        bus_if.Req_Valid  = 1'b1;
        bus_if.Req_Write  = wr;
        bus_if.Req_Size   = sz;
        bus_if.Req_Signed = sg;
        bus_if.Req_Addr   = ad;
        bus_if.Req_WData  = wd;
        n = 0;
        while (!bus_if.Req_Ready && n < 20) begin
            @(negedge Clk_m);
            n++;
        end
        @(posedge Clk_m);
        #1;
        bus_if.Req_Valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge Clk_m);
            #1;
            lat++;
            if (bus_if.Rsp_Valid) got = 1'b1;
        end
        if (!got) checkOutput("rsp_timeout", 32'(got), 32'd1);
        rd = bus_if.Rsp_RData;
        er = bus_if.Rsp_Err;
        @(posedge Clk_m);
        #1;
        checkOutput("pulse_len", 32'(bus_if.Rsp_Valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we_before;

    // Back-to-back vectors with their expected responses.
    logic        b_wr   [8] = '{1, 0, 1, 0, 0, 0, 1, 0};
    logic [1:0]  b_sz   [8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic        b_sg   [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic [7:0]  b_ad   [8] = '{8'h0C, 8'h0C, 8'h0E, 8'h0F, 8'h0C, 8'h02, 8'h0E, 8'h0C};
    logic [31:0] b_wd   [8] = '{32'hDEADBEEF, 0, 32'h7F, 0, 0, 0, 32'h1234, 0};
    logic        b_eerr [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] b_edat [8] = '{0, 32'hDEADBEEF, 0, 32'h000000DE, 32'hFFFFBEEF, 0, 0, 32'h1234BEEF};

    initial begin
        for (int i = 0; i < 64; i++) ram_mem[i] = 32'h0;
        bus_if.Req_Valid  = 1'b0;
        bus_if.Req_Write  = 1'b0;
        bus_if.Req_Size   = 2'b00;
        bus_if.Req_Signed = 1'b0;
        bus_if.Req_Addr   = 8'h00;
        bus_if.Req_WData  = 32'h0;

        #12;
        checkOutput("rst_ready", 32'(bus_if.Req_Ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus_if.Rsp_Valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(bus_if.Rsp_Err), 32'd0);
        checkOutput("rst_rdata", bus_if.Rsp_RData, 32'h0);
        checkOutput("rst_we", 32'(bus_if.Ram_We), 32'd0);
        checkOutput("rst_addr", 32'(bus_if.Ram_Addr), 32'd0);
        checkOutput("rst_din", bus_if.Ram_Din, 32'h0);
        @(negedge Clk_m);
        Rst_m = 1'b0;

        // Word store then word load.
        applyStimulus(1, 2'b10, 0, 8'h00, 32'h11112222, rd, er, lat);
        checkOutput("wst_lat", 32'(lat), 32'd1);
        checkOutput("wst_err", 32'(er), 32'd0);
        applyStimulus(0, 2'b10, 0, 8'h00, 32'h0, rd, er, lat);
        checkOutput("wld_data", rd, 32'h11112222);
        checkOutput("wld_lat", 32'(lat), 32'd2);
        checkOutput("wld_err", 32'(er), 32'd0);

        // Byte read-modify-write and byte loads.
        applyStimulus(1, 2'b10, 0, 8'h04, 32'h33334444, rd, er, lat);
        applyStimulus(1, 2'b00, 0, 8'h05, 32'hFFFFFFA5, rd, er, lat);
        checkOutput("bst_lat", 32'(lat), 32'd2);
        checkOutput("bst_err", 32'(er), 32'd0);
        applyStimulus(0, 2'b10, 0, 8'h04, 32'h0, rd, er, lat);
        checkOutput("bst_word", rd, 32'h3333A544);
        applyStimulus(0, 2'b00, 1, 8'h05, 32'h0, rd, er, lat);
        checkOutput("bld_signed", rd, 32'hFFFFFFA5);
        applyStimulus(0, 2'b00, 0, 8'h05, 32'h0, rd, er, lat);
        checkOutput("bld_unsigned", rd, 32'h000000A5);

        // Halfword read-modify-write and halfword loads.
        applyStimulus(1, 2'b10, 0, 8'h08, 32'h55556666, rd, er, lat);
        applyStimulus(1, 2'b01, 0, 8'h0A, 32'h00008001, rd, er, lat);
        checkOutput("hst_lat", 32'(lat), 32'd2);
        applyStimulus(0, 2'b10, 0, 8'h08, 32'h0, rd, er, lat);
        checkOutput("hst_word", rd, 32'h80016666);
        applyStimulus(0, 2'b01, 1, 8'h0A, 32'h0, rd, er, lat);
        checkOutput("hld_signed", rd, 32'hFFFF8001);
        applyStimulus(0, 2'b01, 0, 8'h0A, 32'h0, rd, er, lat);
        checkOutput("hld_unsigned", rd, 32'h00008001);

        // Misaligned and illegal requests.
        we_before = we_count;
        applyStimulus(0, 2'b10, 0, 8'h03, 32'h0, rd, er, lat);
        checkOutput("err_wld_err", 32'(er), 32'd1);
        checkOutput("err_wld_data", rd, 32'h0);
        checkOutput("err_wld_lat", 32'(lat), 32'd1);
        applyStimulus(1, 2'b01, 0, 8'h01, 32'hBBBB, rd, er, lat);
        checkOutput("err_hst_err", 32'(er), 32'd1);
        checkOutput("err_hst_lat", 32'(lat), 32'd1);
        applyStimulus(1, 2'b11, 0, 8'h10, 32'hCCCC, rd, er, lat);
        checkOutput("err_size_err", 32'(er), 32'd1);
        checkOutput("err_size_data", rd, 32'h0);
        checkOutput("err_no_write", 32'(we_count - we_before), 32'd0);
        applyStimulus(0, 2'b10, 0, 8'h00, 32'h0, rd, er, lat);
        checkOutput("err_ram_intact", rd, 32'h11112222);

        // Back-to-back requests with valid held high.
        busy_cnt  = 0;
        rsp_count = 0;
        mon_on    = 1'b1;
        @(negedge Clk_m);
        for (int i = 0; i < 8; i++) begin
            int n;
            bus_if.Req_Valid  = 1'b1;
            bus_if.Req_Write  = b_wr[i];
            bus_if.Req_Size   = b_sz[i];
            bus_if.Req_Signed = b_sg[i];
            bus_if.Req_Addr   = b_ad[i];
            bus_if.Req_WData  = b_wd[i];
            n = 0;
            while (!bus_if.Req_Ready && n < 20) begin
                @(negedge Clk_m);
                n++;
            end
            @(posedge Clk_m);
            #1;
        end
        bus_if.Req_Valid = 1'b0;
        for (int n = 0; n < 40 && rsp_count < 8; n++) @(posedge Clk_m);
        @(posedge Clk_m);
        #2;
        mon_on = 1'b0;
        checkOutput("b2b_count", 32'(rsp_count), 32'd8);
        checkOutput("b2b_busy", 32'(busy_cnt), 32'd14);
        for (int i = 0; i < 8 && i < rsp_count; i++) begin
            checkOutput($sformatf("b2b_err_%0d", i), 32'(rsp_err[i]), 32'(b_eerr[i]));
            if (!b_wr[i] || b_eerr[i])
                checkOutput($sformatf("b2b_data_%0d", i), rsp_data[i], b_edat[i]);
        end

        // Reset in the middle of a byte read-modify-write.
        @(negedge Clk_m);
        bus_if.Req_Valid  = 1'b1;
        bus_if.Req_Write  = 1'b1;
        bus_if.Req_Size   = 2'b00;
        bus_if.Req_Signed = 1'b0;
        bus_if.Req_Addr   = 8'h05;
        bus_if.Req_WData  = 32'h000000A5;
        @(posedge Clk_m);
        #1;
        bus_if.Req_Valid = 1'b0;
        checkOutput("mid_busy", 32'(bus_if.Req_Ready), 32'd0);
        Rst_m = 1'b1;
        #1;
        checkOutput("mrst_ready", 32'(bus_if.Req_Ready), 32'd1);
        checkOutput("mrst_rsp_valid", 32'(bus_if.Rsp_Valid), 32'd0);
        checkOutput("mrst_rsp_err", 32'(bus_if.Rsp_Err), 32'd0);
        checkOutput("mrst_rdata", bus_if.Rsp_RData, 32'h0);
        checkOutput("mrst_we", 32'(bus_if.Ram_We), 32'd0);
        checkOutput("mrst_addr", 32'(bus_if.Ram_Addr), 32'd0);
        checkOutput("mrst_din", bus_if.Ram_Din, 32'h0);
        @(negedge Clk_m);
        Rst_m = 1'b0;
        applyStimulus(0, 2'b10, 0, 8'h04, 32'h0, rd, er, lat);
        checkOutput("mrst_ram_intact", rd, 32'h3333A544);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
